// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the two-port cache arbiter.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef logic port_id_t;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/cache_port_arbiter_if.sv
// Requester-side and cache-side signals of the arbiter, bundled with the arbiter (master) and environment (slave) views.
interface cache_port_arbiter_if
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req0;
    logic              rw0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic              req1;
    logic              rw1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              err_sticky;
    logic              busy;
    logic              c_strobe;
    logic              c_rw;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_rdy;
    logic [DATA_W-1:0] c_rdata;

    modport master (
        input  req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, c_rdy, c_rdata,
        output ack0, ack1, rdata, err, err_sticky, busy, c_strobe, c_rw, c_addr, c_wdata
    );

    modport slave (
        output req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, c_rdy, c_rdata,
        input  ack0, ack1, rdata, err, err_sticky, busy, c_strobe, c_rw, c_addr, c_wdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-request round-robin picker: on a tie the port that did not win last time is chosen.
module rr_arb2
    import cache_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  port_id_t   i_last_grant,
    output logic       o_gnt_valid,
    output port_id_t   o_gnt_id
);

    // Pick the granted port from the pending requests
    always_comb begin
        o_gnt_valid = |i_req;
        case (i_req)
            2'b01:   o_gnt_id = 1'b0;
            2'b10:   o_gnt_id = 1'b1;
            2'b11:   o_gnt_id = ~i_last_grant;
            default: o_gnt_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one cache controller between instruction (port 0) and data (port 1) requesters,
// with a watchdog that turns a hung cache transaction into an error response.
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    cache_port_arbiter_if.master bus
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            r_state, w_next;
    port_id_t          r_owner, w_owner_n;
    port_id_t          r_last_grant, w_last_n;
    logic [CNT_W-1:0]  r_cnt, w_cnt_n;
    logic              r_err_flag, w_err_flag_n;
    logic              r_err_sticky, w_sticky_n;
    logic              r_c_rw, w_c_rw_n;
    logic [ADDR_W-1:0] r_c_addr, w_c_addr_n;
    logic [DATA_W-1:0] r_c_wdata, w_c_wdata_n;
    logic [DATA_W-1:0] r_rdata, w_rdata_n;
    logic              r_c_strobe, w_strobe_n;
    logic              r_ack0, w_ack0_n;
    logic              r_ack1, w_ack1_n;
    logic              r_err, w_err_n;
    logic              r_busy, w_busy_n;
    logic              w_gnt_valid;
    port_id_t          w_gnt_id;
    logic              w_timeout;

    rr_arb2 u_rr_arb2 (
        .i_req        ({bus.req1, bus.req0}),
        .i_last_grant (r_last_grant),
        .o_gnt_valid  (w_gnt_valid),
        .o_gnt_id     (w_gnt_id)
    );

    assign w_timeout = (r_cnt == CNT_LAST);

    // State and output registers; outputs are registered from their next-state values
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_err_flag   <= 1'b0;
            r_err_sticky <= 1'b0;
            r_c_rw       <= 1'b0;
            r_c_addr     <= '0;
            r_c_wdata    <= '0;
            r_rdata      <= '0;
            r_c_strobe   <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_owner      <= w_owner_n;
            r_last_grant <= w_last_n;
            r_cnt        <= w_cnt_n;
            r_err_flag   <= w_err_flag_n;
            r_err_sticky <= w_sticky_n;
            r_c_rw       <= w_c_rw_n;
            r_c_addr     <= w_c_addr_n;
            r_c_wdata    <= w_c_wdata_n;
            r_rdata      <= w_rdata_n;
            r_c_strobe   <= w_strobe_n;
            r_ack0       <= w_ack0_n;
            r_ack1       <= w_ack1_n;
            r_err        <= w_err_n;
            r_busy       <= w_busy_n;
        end
    end

    // Next-state logic; a cache Rdy wins over the watchdog in the same cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid) w_next = ISSUE;
                else             w_next = IDLE;
            end
            ISSUE: w_next = WAIT;
            WAIT: begin
                if (bus.c_rdy || w_timeout) w_next = RESP;
                else                        w_next = WAIT;
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath updates and next values of the registered outputs
    always_comb begin
        w_owner_n    = r_owner;
        w_last_n     = r_last_grant;
        w_cnt_n      = r_cnt;
        w_err_flag_n = r_err_flag;
        w_sticky_n   = r_err_sticky;
        w_c_rw_n     = r_c_rw;
        w_c_addr_n   = r_c_addr;
        w_c_wdata_n  = r_c_wdata;
        w_rdata_n    = r_rdata;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_owner_n = w_gnt_id;
                    if (w_gnt_id == 1'b1) begin
                        w_c_rw_n    = bus.rw1;
                        w_c_addr_n  = bus.addr1;
                        w_c_wdata_n = bus.wdata1;
                    end else begin
                        w_c_rw_n    = bus.rw0;
                        w_c_addr_n  = bus.addr0;
                        w_c_wdata_n = bus.wdata0;
                    end
                end else begin
                    w_owner_n = r_owner;
                end
            end
            ISSUE: w_cnt_n = '0;
            WAIT: begin
                if (bus.c_rdy) begin
                    if (r_c_rw) w_rdata_n = '0;
                    else        w_rdata_n = bus.c_rdata;
                end else if (w_timeout) begin
                    w_rdata_n    = '0;
                    w_err_flag_n = 1'b1;
                    w_sticky_n   = 1'b1;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            RESP: begin
                w_last_n     = r_owner;
                w_err_flag_n = 1'b0;
            end
            default: w_cnt_n = '0;
        endcase
        w_strobe_n = (w_next == ISSUE);
        w_busy_n   = (w_next != IDLE);
        w_ack0_n   = (w_next == RESP) && (w_owner_n == 1'b0);
        w_ack1_n   = (w_next == RESP) && (w_owner_n == 1'b1);
        w_err_n    = (w_next == RESP) && w_err_flag_n;
    end

    assign bus.ack0       = r_ack0;
    assign bus.ack1       = r_ack1;
    assign bus.rdata      = r_rdata;
    assign bus.err        = r_err;
    assign bus.err_sticky = r_err_sticky;
    assign bus.busy       = r_busy;
    assign bus.c_strobe   = r_c_strobe;
    assign bus.c_rw       = r_c_rw;
    assign bus.c_addr     = r_c_addr;
    assign bus.c_wdata    = r_c_wdata;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Randomized bench for cache_port_arbiter with a transaction-level reference model and a
// behavioural cache responder whose latency is chosen per transaction.
module tb_cache_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cache_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    cache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // requester and cache-side stimulus
    logic          tb_req [2];
    logic          tb_rw  [2];
    logic [AW-1:0] tb_addr[2];
    logic [DW-1:0] tb_wdata[2];
    logic          tb_rdy;
    logic [DW-1:0] tb_rdata;

    assign bus.req0    = tb_req[0];
    assign bus.rw0     = tb_rw[0];
    assign bus.addr0   = tb_addr[0];
    assign bus.wdata0  = tb_wdata[0];
    assign bus.req1    = tb_req[1];
    assign bus.rw1     = tb_rw[1];
    assign bus.addr1   = tb_addr[1];
    assign bus.wdata1  = tb_wdata[1];
    assign bus.c_rdy   = tb_rdy;
    assign bus.c_rdata = tb_rdata;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // reference model: one in-flight transaction described by its strobe and ack cycles
    bit          m_inflight = 1'b0;
    int          m_s = 0, m_due = 0, m_free_from = 0;
    bit          m_owner = 1'b0, m_last = 1'b1, m_rw = 1'b0, m_err = 1'b0, m_sticky = 1'b0;
    logic [15:0] m_addr, m_wdata, m_rdata;
    int          rsp_cyc = -1, stray_cyc = -1;
    logic [15:0] rsp_data = 16'h0000;
    int          next_lat = 1;
    logic [15:0] next_data = 16'h0000;
    bit          rand_lat = 1'b0;
    bit          outstanding[2];
    bit          ack_seen[2];
    int          ack_log[$];

    task automatic new_ops(input int p);
        tb_rw[p]    = 1'($urandom_range(0, 1));
        tb_addr[p]  = 16'($urandom);
        tb_wdata[p] = 16'($urandom);
    endtask

    // an idle arbiter grants whatever is pending at the end of this cycle; strobe follows next cycle
    task automatic model_grant();
        int          lat;
        logic [15:0] d;
        if (!m_inflight && cyc >= m_free_from && (tb_req[0] || tb_req[1])) begin
            if (tb_req[0] && tb_req[1]) m_owner = ~m_last;
            else                        m_owner = tb_req[1];
            m_rw    = tb_rw[m_owner];
            m_addr  = tb_addr[m_owner];
            m_wdata = tb_wdata[m_owner];
            m_s     = cyc + 1;
            lat     = rand_lat ? int'($urandom_range(1, TO + 3)) : next_lat;
            d       = rand_lat ? 16'($urandom) : next_data;
            stray_cyc = rsp_cyc;
            rsp_cyc   = m_s + lat;
            rsp_data  = d;
            if (lat <= TO) begin
                m_due   = m_s + lat + 1;
                m_err   = 1'b0;
                m_rdata = m_rw ? 16'h0000 : d;
            end else begin
                m_due   = m_s + TO + 1;
                m_err   = 1'b1;
                m_rdata = 16'h0000;
            end
            m_inflight = 1'b1;
            outstanding[m_owner] = 1'b1;
        end
    endtask

    task automatic tick();
        bit exp_ack;
        model_grant();
        @(posedge clk);
        #1;
        cyc++;
        tb_rdy   = (cyc == rsp_cyc) || (cyc == stray_cyc);
        tb_rdata = tb_rdy ? rsp_data : 16'($urandom);
        ack_seen[0] = 1'b0;
        ack_seen[1] = 1'b0;
        exp_ack = m_inflight && (cyc == m_due);
        if (exp_ack && m_err) m_sticky = 1'b1;
        chk_eq("ack0", bus.ack0, exp_ack && m_owner == 1'b0);
        chk_eq("ack1", bus.ack1, exp_ack && m_owner == 1'b1);
        chk_eq("strobe", bus.c_strobe, m_inflight && cyc == m_s);
        chk_eq("busy", bus.busy, m_inflight && cyc >= m_s && cyc <= m_due);
        chk_eq("err", bus.err, exp_ack && m_err);
        chk_eq("err_sticky", bus.err_sticky, m_sticky);
        if (m_inflight && cyc == m_s) begin
            chk_eq("c_addr", bus.c_addr, m_addr);
            chk_eq("c_rw", bus.c_rw, m_rw);
            chk_eq("c_wdata", bus.c_wdata, m_wdata);
        end
        if (bus.ack0) ack_log.push_back(0);
        if (bus.ack1) ack_log.push_back(1);
        if (exp_ack) begin
            chk_eq("rdata", bus.rdata, m_rdata);
            chk_eq("c_addr_hold", bus.c_addr, m_addr);
            m_last      = m_owner;
            m_inflight  = 1'b0;
            m_free_from = cyc + 1;
            outstanding[m_owner] = 1'b0;
            ack_seen[m_owner]    = 1'b1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, "_ack0"}, bus.ack0, 1'b0);
        chk_eq({tag, "_ack1"}, bus.ack1, 1'b0);
        chk_eq({tag, "_strobe"}, bus.c_strobe, 1'b0);
        chk_eq({tag, "_busy"}, bus.busy, 1'b0);
        chk_eq({tag, "_err"}, bus.err, 1'b0);
        chk_eq({tag, "_sticky"}, bus.err_sticky, 1'b0);
        chk_eq({tag, "_c_rw"}, bus.c_rw, 1'b0);
        chk_eq({tag, "_c_addr"}, bus.c_addr, 16'h0000);
        chk_eq({tag, "_c_wdata"}, bus.c_wdata, 16'h0000);
        chk_eq({tag, "_rdata"}, bus.rdata, 16'h0000);
    endtask

    task automatic reset_tick(input string tag);
        @(posedge clk);
        #1;
        cyc++;
        chk_all_zero(tag);
    endtask

    task automatic wait_ack(input int p, input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!ack_seen[p] && n < 40);
        chk_eq({tag, "_ack_seen"}, ack_seen[p], 1'b1);
    endtask

    task automatic wait_any_ack(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!ack_seen[0] && !ack_seen[1] && n < 40);
        chk_eq({tag, "_ack_seen"}, ack_seen[0] | ack_seen[1], 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        int exp_seq[4] = '{0, 1, 0, 1};
        for (int p = 0; p < 2; p++) begin
            tb_req[p] = 1'b0;
            tb_rw[p] = 1'b0;
            tb_addr[p] = 16'h0000;
            tb_wdata[p] = 16'h0000;
            outstanding[p] = 1'b0;
            ack_seen[p] = 1'b0;
        end
        tb_rdy   = 1'b0;
        tb_rdata = 16'h0000;

        reset_tick("rst");
        reset_tick("rst");
        reset = 1'b0;
        m_free_from = cyc;

        // single read on port 0
        tb_req[0] = 1'b1; tb_rw[0] = 1'b0; tb_addr[0] = 16'h0040; tb_wdata[0] = 16'h1111;
        next_lat = 3; next_data = 16'hBEEF;
        wait_ack(0, "read0");
        tb_req[0] = 1'b0;
        repeat (2) tick();

        // write on port 1
        tb_req[1] = 1'b1; tb_rw[1] = 1'b1; tb_addr[1] = 16'h0102; tb_wdata[1] = 16'h5A5A;
        next_lat = 2; next_data = 16'hC3C3;
        wait_ack(1, "write1");
        tb_req[1] = 1'b0;
        tick();

        // watchdog timeout, then a normal transaction right after
        tb_req[0] = 1'b1; tb_rw[0] = 1'b0; tb_addr[0] = 16'h0777; tb_wdata[0] = 16'h0000;
        next_lat = TO + 3; next_data = 16'hDEAD;
        wait_ack(0, "timeout");
        tb_addr[0] = 16'h0778;
        next_lat = 1; next_data = 16'h4321;
        wait_ack(0, "after_timeout");
        tb_req[0] = 1'b0;
        tick();

        // Rdy on the last WAIT cycle still completes normally
        tb_req[1] = 1'b1; tb_rw[1] = 1'b0; tb_addr[1] = 16'h0ABC;
        next_lat = TO; next_data = 16'h1234;
        wait_ack(1, "last_wait");
        tb_req[1] = 1'b0;
        tick();

        // requester drops req in the middle of WAIT
        tb_req[0] = 1'b1; tb_rw[0] = 1'b0; tb_addr[0] = 16'h0200;
        next_lat = 5; next_data = 16'h00FF;
        n = 0;
        do begin tick(); n++; end while (!(m_inflight && cyc == m_s + 1) && n < 20);
        tb_req[0] = 1'b0;
        wait_ack(0, "drop_req");
        tick();

        // async reset in the middle of WAIT
        tb_req[0] = 1'b1; tb_rw[0] = 1'b0; tb_addr[0] = 16'h0300;
        next_lat = TO + 3; next_data = 16'h7777;
        n = 0;
        do begin tick(); n++; end while (!(m_inflight && cyc == m_s + 2) && n < 20);
        chk_eq("pre_reset_busy", bus.busy, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        chk_all_zero("async_rst");
        tb_rdy = 1'b0;
        m_inflight = 1'b0; rsp_cyc = -1; stray_cyc = -1;
        m_last = 1'b1; m_sticky = 1'b0;
        outstanding[0] = 1'b0; outstanding[1] = 1'b0;
        reset_tick("in_rst");
        reset_tick("in_rst");
        tb_req[0] = 1'b1; new_ops(0);
        tb_req[1] = 1'b1; new_ops(1);
        reset = 1'b0;
        m_free_from = cyc;
        ack_log.delete();

        // contention after reset: both ports held for four transactions
        rand_lat = 1'b1;
        for (int t = 0; t < 4; t++) begin
            wait_any_ack("contend");
            for (int p = 0; p < 2; p++) if (ack_seen[p]) new_ops(p);
        end
        tb_req[0] = 1'b0;
        tb_req[1] = 1'b0;
        chk_eq("contend_count", ack_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < ack_log.size()) chk_eq("contend_order", ack_log[i], exp_seq[i]);
        tick();

        // randomized traffic on both ports
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (ack_seen[p]) begin
                    tb_req[p] = ($urandom_range(0, 3) != 0);
                    new_ops(p);
                end else if (!tb_req[p] && !outstanding[p]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        tb_req[p] = 1'b1;
                        new_ops(p);
                    end
                end else if (tb_req[p] && outstanding[p] && $urandom_range(0, 15) == 0) begin
                    tb_req[p] = 1'b0;
                end
            end
        end
        tb_req[0] = 1'b0;
        tb_req[1] = 1'b0;
        n = 0;
        while (m_inflight && n < 40) begin tick(); n++; end
        chk_eq("drain", m_inflight, 1'b0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
Shares the single-ported cache controller between two requesters: port 0 is instruction fetch and port 1 is data load/store. The block picks one pending request by round-robin and latches that port's address, write data and RW. It then issues a one-cycle Strobe to the cache controller, waits for its Rdy pulse, and returns read data plus a one-cycle ack to the owning port. A watchdog converts a hung cache transaction into an error response.

Parameters:
ADDR_W, 16, address width of requester and cache buses
DATA_W, 16, data width of requester and cache buses
TIMEOUT, 64, max cycles in WAIT before error response (>=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req0  in  1  port 0 request; held high until ack0
rw0  in  1  port 0 direction: 1=write, 0=read
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
ack0  out  1  port 0 completion pulse
req1, rw1, addr1, wdata1, ack1  same as port 0, for port 1
rdata  out  DATA_W  response data, valid while ack0 or ack1 is high
err  out  1  error pulse; high with ack when the transaction timed out
err_sticky  out  1  set on any timeout; cleared only by reset
busy  out  1  high in every state except IDLE
c_strobe  out  1  Strobe to cache controller
c_rw  out  1  RW to cache controller (1=write)
c_addr  out  ADDR_W  latched address to cache
c_wdata  out  DATA_W  latched write data to cache
c_rdy  in  1  Rdy pulse from cache controller
c_rdata  in  DATA_W  cache read data, valid when c_rdy=1

Behaviour:
- Reset (asynchronous, takes effect immediately)
  - all outputs are 0; c_addr, c_wdata and rdata are 0.
  - state=IDLE; last_grant=1, so port 0 wins the first tie; timeout counter=0.
  - Reset mid-transaction abandons the transaction with no ack. The cache controller is reset by the same net.
- State IDLE
  - Arbitrate on req0/req1. If both are high, grant the port that is not last_grant. If one is high, grant it.
  - On a grant: latch owner, rw/addr/wdata of the owner into c_rw/c_addr/c_wdata; go to ISSUE.
  - If neither req is high, stay in IDLE.
- State ISSUE
  - c_strobe=1 for exactly this one cycle; c_rw/c_addr/c_wdata hold their latched values.
  - Clear the timeout counter; go to WAIT.
- State WAIT
  - c_strobe=0; latched cache buses stay stable.
  - If c_rdy=1: capture c_rdata into rdata when c_rw=0, else set rdata to 0; go to RESP.
  - Else if counter==TIMEOUT-1: set rdata=0, set error flag, set err_sticky; go to RESP.
  - Otherwise increment the counter.
  - c_rdy takes precedence over timeout in the same cycle.
- State RESP
  - ack of the owner=1 for one cycle; err is high if the error flag is set.
  - last_grant<=owner; clear the error flag; go to IDLE.
- Latency
  - req sampled in IDLE at cycle n; c_strobe at n+1.
  - c_rdy at cycle k gives ack at k+1. Minimum request-to-ack is 4 cycles when c_rdy arrives at n+2.
- Handshake rules
  - A requester must hold req and its operands stable until ack. Operands are latched at grant, so later changes have no effect.
  - If req drops mid-transaction, the transaction still completes and ack is still issued.
  - req still high in the cycle after ack is treated as a new request. Round-robin gives the other port priority if it is pending, so there is no starvation.
  - ack0 and ack1 are never high together. c_strobe never fires while busy from a previous issue.
- c_rdy outside WAIT is ignored.
- Counter width is $clog2(TIMEOUT+1); it never wraps.

Decomposition:
- Package cache_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP} (2 bits).
  - port_id_t (1 bit).
  - localparam defaults for ADDR_W and DATA_W.
- Sub-module rr_arb2: combinational two-request round-robin picker.
  - Inputs: req[1:0], last_grant. Outputs: gnt_valid, gnt_id.
  - Instantiated once.
- Everything else (FSM, latches, counter) lives in cache_port_arbiter.

Test Plan:
- Single read on port 0: req0=1, rw0=0, addr0=16'h0040. Model returns c_rdy with c_rdata=16'hBEEF 3 cycles after c_strobe -> c_strobe 1 cycle with c_addr=16'h0040 and c_rw=0; ack0 with rdata=16'hBEEF; ack1 never high.
- Contention: req0 and req1 both high from reset, both held for 4 transactions -> grants alternate 0,1,0,1, one ack per transaction, no cycle with both acks high.
- Write on port 1: rw1=1, addr1=16'h0102, wdata1=16'h5A5A -> c_wdata=16'h5A5A and c_rw=1 at strobe; ack1 with rdata=0.
- Timeout: TIMEOUT=8, model never returns c_rdy -> ack with err=1 exactly 8 WAIT cycles after strobe; err_sticky stays 1; the next transaction succeeds with err=0.
- Edge cases: c_rdy arrives on the last WAIT cycle -> normal ack, err=0. Port 0 drops req0 mid-WAIT -> ack0 still issued.
- Async reset asserted mid-WAIT, between clock edges -> all outputs 0 immediately; no ack after release; IDLE grants port 0 on a tie.
